// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Sequences the 3-stage pipeline around the execution stage. It arbitrates
// bus stalls, jump redirects and multi-cycle operations, drives the pc_reg and
// if_id control lines, and supervises the multi-cycle unit with a timeout.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ex_jump_en/addr   taken branch/jump and its target, from execution
//   ex_hold_en        hold request paired with a jump (it only qualifies the jump)
//   multi_req         execution holds a multi-cycle instruction (level)
//   multi_done        multi-cycle result valid (1-cycle pulse)
//   bus_stall_req     memory/bus not ready (level)
//   pc_jump_en/addr   PC redirect; the address is 0 whenever no redirect is made
//   hold_pc           freeze the PC
//   hold_if_id        freeze the IF/ID register
//   flush_if_id       insert a bubble into IF/ID
//   multi_start       1-cycle start pulse to the multi-cycle unit
//   multi_abort       1-cycle abort pulse on timeout
//   timeout_err       sticky timeout flag, cleared only by reset
//   busy              controller is not in RUN
module pipeline_ctrl #(
  parameter int unsigned FLUSH_CYCLES  = 1,
  parameter int unsigned MULTI_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_jump_en,
  input  logic [31:0] ex_jump_addr,
  input  logic        ex_hold_en,
  input  logic        multi_req,
  input  logic        multi_done,
  input  logic        bus_stall_req,
  output logic        pc_jump_en,
  output logic [31:0] pc_jump_addr,
  output logic        hold_pc,
  output logic        hold_if_id,
  output logic        flush_if_id,
  output logic        multi_start,
  output logic        multi_abort,
  output logic        timeout_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    MULTI = 2'd2,
    STALL = 2'd3
  } state_e;

  localparam logic [7:0] FLUSH_LOAD = 8'(FLUSH_CYCLES);
  localparam logic [7:0] MULTI_LOAD = 8'(MULTI_TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_err_q, timeout_err_d;
  logic       hold_c;

  // ex_hold_en always travels with ex_jump_en, and the jump alone decides the
  // redirect, so the hold request carries no extra information here.
  logic unused_hold;
  assign unused_hold = ex_hold_en;

  // State, the shared flush/timeout counter and the sticky error flag.
  // Reset drops the controller straight back to RUN without any abort pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      cnt_q         <= 8'd0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state and output decode. Every output is held at 0 while rst_n is
  // low so a reset in the middle of an operation silences the pipeline
  // controls at once, even if execution keeps its requests asserted.
  // The counter saturates at 0 so it never wraps while idling in RUN.
  always_comb begin
    state_d       = state_q;
    cnt_d         = (cnt_q != 8'd0) ? cnt_q - 8'd1 : 8'd0;
    timeout_err_d = timeout_err_q;
    pc_jump_en    = 1'b0;
    pc_jump_addr  = 32'h0;
    hold_c        = 1'b0;
    flush_if_id   = 1'b0;
    multi_start   = 1'b0;
    multi_abort   = 1'b0;

    if (rst_n) begin
      unique case (state_q)
        RUN: begin
          // A bus stall outranks everything; the jump or multi-cycle
          // instruction stays in execution and asks again later.
          if (bus_stall_req) begin
            hold_c  = 1'b1;
            state_d = STALL;
          end else if (ex_jump_en) begin
            pc_jump_en   = 1'b1;
            pc_jump_addr = ex_jump_addr;
            flush_if_id  = 1'b1;
            if (FLUSH_CYCLES > 0) begin
              cnt_d   = FLUSH_LOAD;
              state_d = FLUSH;
            end
          end else if (multi_req) begin
            multi_start = 1'b1;
            hold_c      = 1'b1;
            cnt_d       = MULTI_LOAD;
            state_d     = MULTI;
          end
        end

        FLUSH: begin
          // The instruction in execution is a bubble, so jumps and stalls
          // seen here are not acted on until RUN.
          flush_if_id = 1'b1;
          if (cnt_q <= 8'd1) begin
            cnt_d   = 8'd0;
            state_d = RUN;
          end
        end

        MULTI: begin
          // Completion beats a timeout landing in the same cycle.
          if (multi_done) begin
            cnt_d   = 8'd0;
            state_d = RUN;
          end else begin
            hold_c = 1'b1;
            if (cnt_q <= 8'd1) begin
              multi_abort   = 1'b1;
              timeout_err_d = 1'b1;
              cnt_d         = 8'd0;
              state_d       = RUN;
            end
          end
        end

        STALL: begin
          if (bus_stall_req) begin
            hold_c = 1'b1;
          end else begin
            state_d = RUN;
          end
        end

        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  assign hold_pc     = hold_c;
  assign hold_if_id  = hold_c;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != RUN);

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Sequences the 3-stage pipeline around the execution stage.
- Takes jump/hold requests from execution, multi-cycle-unit requests, and bus stall requests.
- Produces PC redirect, PC hold, IF/ID hold and IF/ID flush, plus the start pulse and timeout supervision for a multi-cycle execution unit.
- Sits between execution and the pc_reg/if_id registers.

Parameters:
- FLUSH_CYCLES, 1, extra cycles flush_if_id stays high after a redirect; range 0..7, covers instruction-ROM read latency.
- MULTI_TIMEOUT, 64, max cycles waiting for multi_done before abort; range 1..255.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ex_jump_en  input  1  branch/jump taken, from execution
- ex_jump_addr  input  32  redirect target, from execution
- ex_hold_en  input  1  execution hold request accompanying a jump
- multi_req  input  1  execution holds a multi-cycle instruction, level
- multi_done  input  1  multi-cycle unit result valid, 1-cycle pulse
- bus_stall_req  input  1  memory/bus not ready, level
- pc_jump_en  output  1  load PC with pc_jump_addr
- pc_jump_addr  output  32  PC redirect target
- hold_pc  output  1  freeze PC
- hold_if_id  output  1  freeze IF/ID register
- flush_if_id  output  1  insert bubble (NOP) into IF/ID
- multi_start  output  1  1-cycle start pulse to multi-cycle unit
- multi_abort  output  1  1-cycle abort pulse on timeout
- timeout_err  output  1  sticky multi-cycle timeout flag
- busy  output  1  state != RUN

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset: state=RUN, counters=0, timeout_err=0, and all outputs 0 (pc_jump_addr=32'h0).
- Assertion of rst_n mid-operation aborts any state immediately. No multi_abort pulse is issued on reset.
- States: RUN, FLUSH, MULTI, STALL.
- Priority in RUN, evaluated each cycle: bus_stall_req > ex_jump_en > multi_req.
- RUN, bus_stall_req=1:
  - hold_pc=hold_if_id=1 combinationally, same cycle.
  - Jump and multi request are ignored (the instruction stays in execution and re-requests later).
  - Next state STALL.
- RUN, ex_jump_en=1:
  - Same cycle, combinational: pc_jump_en=1, pc_jump_addr=ex_jump_addr, flush_if_id=1.
  - If FLUSH_CYCLES>0: load cnt=FLUSH_CYCLES, go to FLUSH. Otherwise stay in RUN.
  - ex_hold_en only qualifies the jump; ex_hold_en without ex_jump_en is ignored.
- RUN, multi_req=1 (and no jump):
  - Same cycle: multi_start=1, hold_pc=hold_if_id=1.
  - Load cnt=MULTI_TIMEOUT, go to MULTI.
- FLUSH:
  - flush_if_id=1 and pc_jump_en=0.
  - cnt decrements each cycle; at cnt==1, next state is RUN.
  - New ex_jump_en is ignored (the instruction is a flushed bubble).
  - bus_stall_req is deferred until RUN.
- MULTI:
  - hold_pc=hold_if_id=1; cnt decrements each cycle.
  - multi_done=1: hold released in the same cycle (hold outputs 0), next state RUN.
  - cnt reaches 0 without done: multi_abort=1 for 1 cycle, timeout_err set (sticky until reset), next state RUN.
  - multi_done on the same cycle as the timeout: done wins, no error.
  - multi_start is never reissued while in MULTI.
- STALL:
  - hold_pc=hold_if_id=1 while bus_stall_req=1.
  - When bus_stall_req falls, hold drops the same cycle and the state returns to RUN.
  - The pending jump/multi is re-evaluated from RUN on the following cycle.
- multi_done outside MULTI is ignored.
- pc_jump_addr is 0 whenever pc_jump_en=0.
- Counters are 8-bit, no wrap: they saturate at 0.
- busy is high in FLUSH, MULTI and STALL.

Test Plan:
- Reset release, then a jump:
  - ex_jump_en=1, addr=32'h0000_0040 for 1 cycle.
  - Same cycle: pc_jump_en=1, pc_jump_addr=32'h40, flush_if_id=1.
  - With FLUSH_CYCLES=1: flush_if_id=1 one more cycle, then RUN with busy=0.
- Multi-cycle op:
  - multi_req=1, multi_done pulsed 5 cycles later.
  - multi_start is exactly one pulse.
  - hold_pc=hold_if_id=1 for 5 cycles, 0 in the done cycle; timeout_err=0.
- Timeout:
  - MULTI_TIMEOUT=4, multi_req=1, no done.
  - multi_abort pulses on the 5th cycle; timeout_err=1 and stays 1 until rst_n=0.
- Simultaneous bus_stall_req=1 and ex_jump_en=1 in RUN:
  - pc_jump_en=0 and hold_pc=1.
  - After stall drops, the next cycle's jump redirects to ex_jump_addr.
- Stall for 3 cycles: hold outputs high exactly 3 cycles, busy high during STALL.
- rst_n=0 asserted mid-MULTI (cnt=30): all outputs 0 immediately (asynchronous), state RUN, no multi_abort.
